// File: rtl/pipe_pkg.sv
// Constants and types shared by the 5-stage MIPS pipeline.
// Fetch-queue entries pair the instruction with its PC+4.
package pipe_pkg;

    localparam int unsigned WORD = 32;

    localparam logic [WORD-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [WORD-1:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [WORD-1:0] pc_plus_4;
        logic [WORD-1:0] instr;
    } fq_entry_t;

    function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: a side FIFO of issued PC+4 values is matched against
// returning instruction words, which land in a shift-register queue whose head is a flop.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            issue,
    input  logic [WORD-1:0] issue_pc,
    input  logic            push,
    input  logic [WORD-1:0] push_instr,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic            head_valid,
    output logic [WORD-1:0] head_instr,
    output logic [WORD-1:0] head_pc_plus_4
);

    // Side FIFO of PC+4 for requests whose responses will be kept.
    logic [WORD-1:0] pcf_q [DEPTH];
    logic [WORD-1:0] pcf_d [DEPTH];
    logic [AW-1:0]   pc_wr_q, pc_wr_d;
    logic [AW-1:0]   pc_rd_q, pc_rd_d;

    // Data queue; invalid slots are held at zero so the head reads as a NOP bubble.
    fq_entry_t       ent_q [DEPTH];
    fq_entry_t       ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;

    logic            pop_eff;
    logic            push_eff;
    logic [CW-1:0]   wr_idx;

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count = count + CW'(vld_q[i]);
        end
    end

    assign pop_eff  = pop && vld_q[0];
    assign wr_idx   = count - CW'(pop_eff);
    assign push_eff = push && (wr_idx < CW'(DEPTH));

    always_comb begin
        pcf_d   = pcf_q;
        pc_wr_d = pc_wr_q;
        pc_rd_d = pc_rd_q;
        if (flush) begin
            pc_wr_d = '0;
            pc_rd_d = '0;
        end else begin
            if (issue) begin
                pcf_d[pc_wr_q] = issue_pc + PC_STEP;
                pc_wr_d        = pc_wr_q + AW'(1);
            end
            if (push) begin
                pc_rd_d = pc_rd_q + AW'(1);
            end
        end
    end

    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
        end else begin
            if (pop_eff) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    ent_d[i] = ent_q[i+1];
                    vld_d[i] = vld_q[i+1];
                end
                ent_d[DEPTH-1] = '0;
                vld_d[DEPTH-1] = 1'b0;
            end
            if (push_eff) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CW'(i)) begin
                        ent_d[i] = {pcf_q[pc_rd_q], push_instr};
                        vld_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_wr_q <= '0;
            pc_rd_q <= '0;
            vld_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pcf_q[i] <= '0;
                ent_q[i] <= '0;
            end
        end else begin
            pc_wr_q <= pc_wr_d;
            pc_rd_q <= pc_rd_d;
            vld_q   <= vld_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pcf_q[i] <= pcf_d[i];
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign head_valid     = vld_q[0];
    assign head_instr     = ent_q[0].instr;
    assign head_pc_plus_4 = ent_q[0].pc_plus_4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word fetches,
// buffers responses in order and drops responses made stale by an ID redirect.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            redirectD,
    input  logic [WORD-1:0] redirect_pcD,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    output logic [WORD-1:0] instrF,
    output logic [WORD-1:0] pc_plus_4F,
    output logic            validF
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [WORD-1:0] pc_q, pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [0:0]      state_q, state_d;

    logic [CW-1:0]   fq_count;
    logic [CW:0]     credit_used;
    logic            grant;
    logic            pop;
    logic            push;
    logic            drop_rsp;

    assign pop         = validF && !stallF;
    assign credit_used = {1'b0, outst_q} + {1'b0, fq_count} - (CW+1)'(pop);

    // Held low while in reset so the bus is idle until the first cycle after release.
    assign imem_req  = rst && !redirectD && (credit_used < (CW+1)'(FQ_DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;

    assign drop_rsp = imem_rvalid && (redirectD || (state_q == ST_FLUSH));
    assign push     = imem_rvalid && !drop_rsp;

    always_comb begin
        pc_d = pc_q;
        if (redirectD) begin
            pc_d = word_align(redirect_pcD);
        end else if (grant) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    assign outst_d = outst_q + CW'(grant) - CW'(imem_rvalid);

    // Outstanding already counts responses still owed to an earlier flush,
    // so a redirect re-derives the drop count from it.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirectD) begin
            drop_cnt_d = outst_q - CW'(imem_rvalid);
        end else if (imem_rvalid && (state_q == ST_FLUSH)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (redirectD && (drop_cnt_d != '0)) state_d = ST_FLUSH;
            ST_FLUSH: if (drop_cnt_d == '0) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            drop_cnt_q <= '0;
            state_q    <= ST_FETCH;
        end else begin
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
        end
    end

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_fetch_queue (
        .clk           (clk),
        .rst           (rst),
        .flush         (redirectD),
        .issue         (grant),
        .issue_pc      (pc_q),
        .push          (push),
        .push_instr    (imem_rdata),
        .pop           (pop),
        .count         (fq_count),
        .head_valid    (validF),
        .head_instr    (instrF),
        .head_pc_plus_4(pc_plus_4F)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order variable-latency memory model
// and a scoreboard of the expected instruction stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF;
    logic        redirectD;
    logic [31:0] redirect_pcD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrF;
    logic [31:0] pc_plus_4F;
    logic        validF;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .FQ_DEPTH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallF      (stallF),
        .redirectD   (redirectD),
        .redirect_pcD(redirect_pcD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instrF      (instrF),
        .pc_plus_4F  (pc_plus_4F),
        .validF      (validF)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          outst   = 0;
    int          max_outst = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc;
    bit          sb_en = 1'b0;
    logic [31:0] held;
    bit          hit;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the next negedge.
    task automatic step();
        bit          g;
        bit          c;
        logic [31:0] a;
        g = imem_req && imem_gnt;
        a = imem_addr;
        c = imem_rvalid;
        if (sb_en && rst && validF && !stallF && !redirectD) begin
            check_eq("pop_pc4", pc_plus_4F, exp_pc + 32'd4);
            check_eq("pop_instr", instrF, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (c && mq_addr.size() > 0) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            outst--;
        end
        if (g) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat);
            outst++;
            if (outst > max_outst) max_outst = outst;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
            outst = 0;
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stallF = 1'b0; redirectD = 1'b0; redirect_pcD = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", 32'(validF), 32'd0);
        check_eq("rst_instr", instrF, 32'h0);
        check_eq("rst_pc4", pc_plus_4F, 32'h0);

        // Streaming from reset, zero-wait memory.
        @(negedge clk);
        imem_gnt = 1'b1; lat = 1; exp_pc = 32'h0; sb_en = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("t1_addr", imem_addr, 32'(4 * i));
            check_eq("t1_valid", 32'(validF), (i >= 2) ? 32'd1 : 32'd0);
            if (i == 0) check_eq("t1_first_req", 32'(imem_req), 32'd1);
            step();
        end

        // Stall 5 cycles mid-stream.
        stallF = 1'b1;
        #1;
        held = instrF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t2_frozen", instrF, held);
            check_eq("t2_valid", 32'(validF), 32'd1);
            if (i >= 1) check_eq("t2_req_full", 32'(imem_req), 32'd0);
            step();
        end
        stallF = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            step();
        end

        // Redirect to 0x100 with two fetches in flight.
        lat = 3;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            #1;
            if (outst == 2) hit = 1'b1;
            else step();
        end
        check_eq("t3_reach_out2", 32'(outst), 32'd2);
        redirectD = 1'b1; redirect_pcD = 32'h0000_0100; exp_pc = 32'h0000_0100;
        #1;
        check_eq("t3_redir_noreq", 32'(imem_req), 32'd0);
        step();
        redirectD = 1'b0;
        #1;
        check_eq("t3_flushed", 32'(validF), 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            #1;
            if (validF) hit = 1'b1;
            else step();
        end
        check_eq("t3_got_valid", 32'(validF), 32'd1);
        check_eq("t3_first_pc4", pc_plus_4F, 32'h0000_0104);
        check_eq("t3_first_instr", instrF, 32'h8C00_0100);
        for (int i = 0; i < 8; i++) begin
            #1;
            step();
        end

        // Grant withheld 3 cycles, then 4-cycle response latency.
        imem_gnt = 1'b0; lat = 4; max_outst = outst;
        #1;
        held = imem_addr;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t4_addr_held", imem_addr, held);
            step();
        end
        imem_gnt = 1'b1;
        for (int i = 0; i < 24; i++) begin
            #1;
            step();
        end
        check_eq("t4_max_outst", 32'(max_outst <= 2), 32'd1);

        // Redirect to 0xFFFF_FFFE with zero-wait memory: wrap to 0.
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            step();
        end
        redirectD = 1'b1; redirect_pcD = 32'hFFFF_FFFE; exp_pc = 32'hFFFF_FFFC;
        #1;
        check_eq("t5_redir_noreq", 32'(imem_req), 32'd0);
        step();
        redirectD = 1'b0;
        #1;
        check_eq("t5_req_r1", 32'(imem_req), 32'd1);
        check_eq("t5_addr_r1", imem_addr, 32'hFFFF_FFFC);
        step();
        #1;
        check_eq("t5_wrap_addr", imem_addr, 32'h0000_0000);
        check_eq("t5_notyet", 32'(validF), 32'd0);
        step();
        #1;
        check_eq("t5_valid_r3", 32'(validF), 32'd1);
        check_eq("t5_pc4_r3", pc_plus_4F, 32'h0000_0000);
        check_eq("t5_instr_r3", instrF, 32'h73FF_FFFC);
        for (int i = 0; i < 4; i++) begin
            #1;
            step();
        end

        // Reset with two fetches in flight.
        lat = 3;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            #1;
            if (outst == 2) hit = 1'b1;
            else step();
        end
        check_eq("t6_reach_out2", 32'(outst), 32'd2);
        rst = 1'b0;
        #1;
        check_eq("t6_valid", 32'(validF), 32'd0);
        check_eq("t6_instr", instrF, 32'h0);
        check_eq("t6_pc4", pc_plus_4F, 32'h0);
        check_eq("t6_req", 32'(imem_req), 32'd0);
        check_eq("t6_addr", imem_addr, 32'h0);
        step();
        rst = 1'b1; lat = 1; exp_pc = 32'h0;
        #1;
        check_eq("t6_first_req", 32'(imem_req), 32'd1);
        check_eq("t6_first_addr", imem_addr, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            #1;
            if (validF) hit = 1'b1;
            else step();
        end
        check_eq("t6_refetch_pc4", pc_plus_4F, 32'h0000_0004);
        for (int i = 0; i < 6; i++) begin
            #1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the PC and issues word fetches to a variable-latency instruction memory over a req/gnt + rvalid handshake. Responses are buffered in a small in-order fetch queue, and the block presents `instrF` / `pc_plus_4F` / `validF` to the IF/ID register. It honours `stallF` from the hazard unit and accepts branch/jump redirects from ID, discarding stale in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `FQ_DEPTH`, 2, fetch-queue entries; power of two, ≥2.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `stallF` input 1: hold output; do not pop the queue.
- `redirectD` input 1: taken branch/jump resolved in ID.
- `redirect_pcD` input 32: redirect target; bits [1:0] forced to 0.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 32: word address (byte address, [1:0]=00).
- `imem_gnt` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: response data valid, in order, ≥1 cycle after grant.
- `imem_rdata` input 32: instruction word.
- `instrF` output 32: head instruction; 32'h0 (NOP) when `validF`=0.
- `pc_plus_4F` output 32: head PC+4; 0 when `validF`=0.
- `validF` output 1: head entry present.

## Operation
- Grant: `imem_req && imem_gnt`. On a grant, the PC advances by 4 (32-bit wrap: FFFF_FFFC→0000_0000).
- Pop: `validF && !stallF`. The IF/ID register captures the head on a pop. It captures the NOP/0 bubble when `validF`=0.
- Credit: `imem_req` = !redirectD && (outstanding + occupancy − pop) < FQ_DEPTH. This guarantees queue space for every response.
- Outstanding counter: +1 on a grant, −1 on `imem_rvalid`. Maximum value is FQ_DEPTH.
- Queue entry = {pc_of_fetch+4, imem_rdata}. A side FIFO of issued PCs matches responses in order; it lives inside the queue.
- FSM:
  - FETCH: normal operation. A `redirectD` with outstanding′>0 moves to FLUSH.
  - FLUSH: `drop_cnt` > 0. Each `imem_rvalid` is discarded and decrements `drop_cnt`. New requests are allowed. Returns to FETCH when `drop_cnt` reaches 0.
- Redirect (any state):
  - Queue emptied.
  - PC ← `redirect_pcD` & ~3.
  - `imem_req` forced 0 that cycle.
  - `drop_cnt` ← outstanding − (imem_rvalid ? 1 : 0) + (existing `drop_cnt` absorbed, i.e., all in-flight responses are dropped).
  - Redirect takes priority over `stallF`.
- Simultaneous events:
  - `rvalid` in the redirect cycle: dropped.
  - Push and pop on a full queue: allowed (credit counts the pop).
  - `stallF` with the queue full: no request is issued and nothing is lost.
- Reset mid-fetch: all in-flight responses are forgotten. The memory is required to be reset on the same `rst`.

## Timing
- Reset values:
  - PC = RESET_PC; outstanding = 0; `drop_cnt` = 0; state = FETCH; queue empty.
  - `imem_req` = 0, `imem_addr` = RESET_PC.
  - `validF` = 0, `instrF` = 0, `pc_plus_4F` = 0.
- First cycle after reset release: `imem_req`=1, `imem_addr`=RESET_PC.
- Latency: grant at N, rvalid at N+k (k≥1), `validF`/`instrF` at N+k+1. Queue outputs are registered.
- Throughput: 1 instr/cycle with `gnt`=1 and k=1 when FQ_DEPTH=2.
- Redirect at cycle R: no request at R. Request to the target at R+1. Target instruction valid at R+3 with a zero-wait memory.
- `imem_addr` is stable while `imem_req`=1 and `imem_gnt`=0.

## Structure
- Shared package `pipe_pkg`: `NOP_INSTR` (32'h0), `RESET_PC_DEFAULT`, `WORD` width (32).
- Sub-module `fetch_queue`: FQ_DEPTH-entry synchronous FIFO of {pc_plus_4, instr}. Has push, pop, flush, count, and registered head outputs.
- `fetch_stage` holds the PC, counters, FSM, credit logic and drop filtering.

## Test plan
- Reset release with `gnt`=1, 1-cycle memory returning the word at address ×1: `imem_addr` sequence 0,4,8,…; `validF` from cycle 2; `pc_plus_4F` = 4,8,12,… one per cycle.
- `stallF` held 5 cycles mid-stream: `instrF` frozen; `imem_req` drops once the queue is full; no instruction lost or duplicated after release.
- `redirectD` to 0x0000_0100 with 2 fetches outstanding: both responses discarded (FLUSH, then FETCH); next `validF` shows `pc_plus_4F`=0x104.
- `gnt` low 3 cycles, then rvalid latency 4: `imem_addr` held; in-order delivery; outstanding never exceeds 2.
- Redirect target 0xFFFF_FFFE: fetch at 0xFFFF_FFFC; next fetch address 0x0000_0000; `pc_plus_4F`=0.
- `rst` asserted with 2 fetches in flight: outputs return to reset values immediately; refetch from RESET_PC.
